// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_pkg
//  Brief    : Shared types and constants for the DIP-switch debouncer.
//  Revision : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    // Debouncer FSM states
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_SETTLING = 1'b1
    } deb_state_t;

    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_STABLE_CYCLES = 100000;

    // Width of a counter able to hold values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : WIDTH-bit two-flop synchroniser for asynchronous inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             cmosClock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two flop stages; only the second one is consumed downstream
    always_ff @(posedge cmosClock) begin
        if (!resetN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
        end
    end

    assign o_sync = r_sync2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : switch_debouncer
//  Brief    : Synchronises and debounces a DIP-switch bank as one vector,
//             with a change strobe and a mask of the flipped bits.
//  Revision : 1.0 - initial release
// ============================================================================
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             cmosClock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] rawSwitch,
    output logic [WIDTH-1:0] debounced,
    output logic             changed,
    output logic [WIDTH-1:0] changedMask,
    output logic             stable
);

    localparam int                 c_CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [WIDTH-1:0]   w_sync;
    deb_state_t         r_state;
    logic [WIDTH-1:0]   r_candidate;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_debounced;
    logic [WIDTH-1:0]   r_changed_mask;
    logic               r_changed;
    logic               r_stable;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .cmosClock (cmosClock),
        .resetN    (resetN),
        .i_async   (rawSwitch),
        .o_sync    (w_sync)
    );

    // Debounce FSM: one shared counter qualifies the whole vector; the
    // stable flag is kept in step with the state register so it is IDLE-true.
    always_ff @(posedge cmosClock) begin
        if (!resetN) begin
            r_state        <= ST_IDLE;
            r_candidate    <= '0;
            r_count        <= '0;
            r_debounced    <= '0;
            r_changed_mask <= '0;
            r_changed      <= 1'b0;
            r_stable       <= 1'b1;
        end else begin
            r_changed <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_sync != r_debounced) begin
                        r_candidate <= w_sync;
                        r_count     <= '0;
                        r_state     <= ST_SETTLING;
                        r_stable    <= 1'b0;
                    end
                end
                ST_SETTLING: begin
                    if (w_sync == r_debounced) begin
                        // Glitch fell back to the accepted value
                        r_count  <= '0;
                        r_state  <= ST_IDLE;
                        r_stable <= 1'b1;
                    end else if (w_sync != r_candidate) begin
                        // Bounce to another pattern: restart qualification
                        r_candidate <= w_sync;
                        r_count     <= '0;
                    end else if (r_count == c_LAST) begin
                        r_debounced    <= r_candidate;
                        r_changed_mask <= r_candidate ^ r_debounced;
                        r_changed      <= 1'b1;
                        r_count        <= '0;
                        r_state        <= ST_IDLE;
                        r_stable       <= 1'b1;
                    end else begin
                        r_count <= r_count + c_ONE;
                    end
                end
                default: begin
                    r_count  <= '0;
                    r_state  <= ST_IDLE;
                    r_stable <= 1'b1;
                end
            endcase
        end
    end

    assign debounced   = r_debounced;
    assign changed     = r_changed;
    assign changedMask = r_changed_mask;
    assign stable      = r_stable;

endmodule : switch_debouncer
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_switch_debouncer
//  Brief    : Self-checking bench for switch_debouncer (STABLE_CYCLES = 4).
//             Reference: the output accepts a value once the last
//             STABLE_CYCLES+1 synchronised samples all equal it and differ
//             from the current output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int W = 8;
    localparam int S = 4;

    logic         cmosClock = 1'b0;
    logic         resetN    = 1'b0;
    logic [W-1:0] rawSwitch = '0;
    logic [W-1:0] debounced;
    logic         changed;
    logic [W-1:0] changedMask;
    logic         stable;

    switch_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .cmosClock   (cmosClock),
        .resetN      (resetN),
        .rawSwitch   (rawSwitch),
        .debounced   (debounced),
        .changed     (changed),
        .changedMask (changedMask),
        .stable      (stable)
    );

    always #5 cmosClock = ~cmosClock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;

    // Reference model state
    logic [W-1:0] rawq[$] = '{8'h00, 8'h00, 8'h00};
    logic [W-1:0] win[$];
    logic [W-1:0] m_deb    = '0;
    logic [W-1:0] m_mask   = '0;
    logic         m_chg    = 1'b0;
    logic         m_stable = 1'b1;

    // Reference model: samples taken at each rising edge
    always @(posedge cmosClock) begin
        logic [W-1:0] inp;
        logic         same;
        if (!resetN) begin
            rawq     = '{8'h00, 8'h00, 8'h00};
            win.delete();
            m_deb    = '0;
            m_mask   = '0;
            m_chg    = 1'b0;
            m_stable = 1'b1;
        end else begin
            rawq.push_back(rawSwitch);
            void'(rawq.pop_front());
            inp = rawq[0];           // raw value sampled two edges ago
            win.push_back(inp);
            if (win.size() > S + 1) void'(win.pop_front());
            same = (win.size() == S + 1);
            foreach (win[i]) if (win[i] != win[0]) same = 1'b0;
            m_chg = 1'b0;
            if (same && win[0] != m_deb) begin
                m_mask = win[0] ^ m_deb;
                m_deb  = win[0];
                m_chg  = 1'b1;
            end
            m_stable = (inp == m_deb);
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock, then compare every output against the model
    task automatic cycle();
        @(posedge cmosClock);
        #1;
        check("debounced", debounced, m_deb);
        check("changed", {7'b0, changed}, {7'b0, m_chg});
        check("changedMask", changedMask, m_mask);
        check("stable", {7'b0, stable}, {7'b0, m_stable});
        if (changed) begin
            n_pulses++;
            n_checks++;
            assert (changedMask != '0)
            else begin
                n_fail++;
                $error("FAIL strobe_mask_zero: observed %h expected nonzero", changedMask);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        int p0;
        // Reset with A5 on the pins
        rawSwitch = 8'hA5;
        resetN    = 1'b0;
        run(3);
        check("reset_deb", debounced, 8'h00);
        check("reset_chg", {7'b0, changed}, 8'h00);
        check("reset_stable", {7'b0, stable}, 8'h01);
        p0 = n_pulses;
        resetN = 1'b1;
        run(10);
        check("release_deb", debounced, 8'hA5);
        check("release_pulses", 8'(n_pulses - p0), 8'd1);

        // Settle to 00, then clean change to 0F
        rawSwitch = 8'h00;
        run(10);
        p0 = n_pulses;
        rawSwitch = 8'h0F;
        run(3);
        check("settling_stable", {7'b0, stable}, 8'h00);
        run(7);
        check("clean_deb", debounced, 8'h0F);
        check("clean_mask", changedMask, 8'h0F);
        check("clean_pulses", 8'(n_pulses - p0), 8'd1);

        // Glitch reject
        p0 = n_pulses;
        rawSwitch = 8'h1F;
        run(2);
        rawSwitch = 8'h0F;
        run(10);
        check("glitch_deb", debounced, 8'h0F);
        check("glitch_pulses", 8'(n_pulses - p0), 8'd0);
        check("glitch_stable", {7'b0, stable}, 8'h01);

        // Bounce restart from 00
        rawSwitch = 8'h00;
        run(10);
        p0 = n_pulses;
        rawSwitch = 8'h01;
        run(2);
        rawSwitch = 8'h03;
        run(12);
        check("bounce_deb", debounced, 8'h03);
        check("bounce_pulses", 8'(n_pulses - p0), 8'd1);

        // Reset while settling with count = 2
        p0 = n_pulses;
        rawSwitch = 8'h55;
        run(5);
        check("mid_count", 8'(dut.r_count), 8'd2);
        resetN = 1'b0;
        run(1);
        check("midrst_deb", debounced, 8'h00);
        check("midrst_mask", changedMask, 8'h00);
        check("midrst_stable", {7'b0, stable}, 8'h01);
        check("midrst_pulses", 8'(n_pulses - p0), 8'd0);
        run(2);
        resetN = 1'b1;
        run(12);
        check("reacq_deb", debounced, 8'h55);
        check("reacq_pulses", 8'(n_pulses - p0), 8'd1);

        // Long hold
        p0 = n_pulses;
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (i % 100 == 0) check("hold_count", 8'(dut.r_count), 8'd0);
        end
        check("hold_pulses", 8'(n_pulses - p0), 8'd0);

        // Randomised bouncing with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            if ($urandom_range(0, 49) == 0) begin
                resetN = 1'b0;
                run($urandom_range(1, 2));
                resetN = 1'b1;
            end
            case ($urandom_range(0, 3))
                0:       rawSwitch = debounced;
                1:       rawSwitch = debounced ^ (8'h01 << $urandom_range(0, 7));
                default: rawSwitch = 8'($urandom);
            endcase
            run($urandom_range(1, 8));
        end
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_switch_debouncer
`default_nettype wire
